// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot encoder/decoder family.
package onehot_pkg;

  localparam int unsigned CODE_W_DEF = 4;
  localparam int unsigned TAG_W_DEF  = 2;

  function automatic int unsigned idx_width(input int unsigned code_w);
    return (code_w > 1) ? $clog2(code_w) : 1;
  endfunction

  localparam int unsigned IDX_W_DEF = idx_width(CODE_W_DEF);

  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic                 err;
    logic [TAG_W_DEF-1:0] tag;
  } rsp_entry_t;

  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull
  } occ_state_e;

endpackage

// File: rtl/onehot_rsp_fifo.sv
// In-order synchronous response FIFO with explicit EMPTY/PARTIAL/FULL occupancy state.
module onehot_rsp_fifo
  import onehot_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = rsp_entry_t,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  entry_t       wdata,
  input  logic         pop,
  output entry_t       rdata,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  occ_state_e       state_q, state_d;
  logic             do_push, do_pop;

  assign do_push = push && (state_q != StFull);
  assign do_pop  = pop && (state_q != StEmpty);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StEmpty: begin
        if (do_push) state_d = StPartial;
      end
      StPartial: begin
        if (do_push && !do_pop && (count_q == FullCnt - 1'b1)) state_d = StFull;
        else if (do_pop && !do_push && (count_q == 1)) state_d = StEmpty;
      end
      StFull: begin
        if (do_pop) state_d = StPartial;
      end
      default: state_d = StEmpty;
    endcase

    // A flush wins over any push/pop in the same cycle.
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StEmpty;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (state_q == StFull);
  assign empty = (state_q == StEmpty);
  assign count = count_q;

endmodule

// File: rtl/onehot_decode_responder.sv
// Decodes one-hot request codes into {idx, err, tag} responses buffered in an in-order FIFO,
// and keeps a saturating count of malformed codes.
module onehot_decode_responder
  import onehot_pkg::*;
#(
  parameter int unsigned CODE_W = CODE_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CODE_W-1:0]         req_code,
  input  logic [TAG_W-1:0]          req_tag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(CODE_W)-1:0] rsp_idx,
  output logic                      rsp_err,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam int unsigned IDX_W = idx_width(CODE_W);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Lowest set bit gives the index; anything other than exactly one set bit is an error.
  function automatic entry_t decode(input logic [CODE_W-1:0] code, input logic [TAG_W-1:0] tag);
    entry_t      e;
    int unsigned ones;
    e    = '0;
    ones = 0;
    for (int i = 0; i < CODE_W; i++) begin
      if (code[i]) begin
        if (ones == 0) e.idx = IDX_W'(i);
        ones = ones + 1;
      end
    end
    e.err = (ones != 1);
    e.tag = tag;
    return e;
  endfunction

  logic             rst_q;
  logic             push, pop;
  entry_t           wr_entry, head_entry, rd_entry;
  logic             fifo_full, fifo_empty;
  logic [PTR_W:0]   fifo_count;
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  assign wr_entry  = decode(req_code, req_tag);
  assign req_ready = !rst_q && !clear && !fifo_full;
  assign push      = req_valid && req_ready;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;

  onehot_rsp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Storage is not reset, so mask the head when nothing is buffered.
  assign head_entry = fifo_empty ? '0 : rd_entry;
  assign rsp_idx    = head_entry.idx;
  assign rsp_err    = head_entry.err;
  assign rsp_tag    = head_entry.tag;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_cnt_q <= '0;
    end else if (push && wr_entry.err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_onehot_decode_responder.sv
// Randomized self-checking bench with a queue-based reference model; a second instance
// with a 2-bit error counter exercises saturation on the same stimulus.
module tb_onehot_decode_responder;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_code = '0;
  logic [1:0] req_tag = '0;
  logic       rsp_ready = 1'b0;

  logic       req_ready, rsp_valid, rsp_err;
  logic [1:0] rsp_idx, rsp_tag;
  logic [7:0] err_cnt;

  logic       s_req_ready, s_rsp_valid, s_rsp_err;
  logic [1:0] s_rsp_idx, s_rsp_tag;
  logic [1:0] s_err_cnt;

  always #5 clk = ~clk;

  onehot_decode_responder dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_code  (req_code),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_idx   (rsp_idx),
    .rsp_err   (rsp_err),
    .rsp_tag   (rsp_tag),
    .err_cnt   (err_cnt)
  );

  onehot_decode_responder #(
    .CNT_W (2)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (s_req_ready),
    .req_code  (req_code),
    .req_tag   (req_tag),
    .rsp_valid (s_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_idx   (s_rsp_idx),
    .rsp_err   (s_rsp_err),
    .rsp_tag   (s_rsp_tag),
    .err_cnt   (s_err_cnt)
  );

  typedef struct {
    int unsigned idx;
    bit          err;
    int unsigned tag;
  } exp_t;

  exp_t        m_q[$];
  bit          m_rst_q = 1'b1;
  int unsigned m_err = 0;
  int unsigned m_err_sat = 0;
  bit          m_acc = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model_decode(input logic [3:0] c, input logic [1:0] t);
    exp_t       e;
    logic [3:0] low;
    low   = c & (~c + 4'd1);
    e.err = ($countones(c) != 1);
    case (low)
      4'b0010: e.idx = 1;
      4'b0100: e.idx = 2;
      4'b1000: e.idx = 3;
      default: e.idx = 0;
    endcase
    e.tag = t;
    return e;
  endfunction

  function automatic logic [3:0] onehot(input int unsigned n);
    return 4'(1 << (n % 4));
  endfunction

  // One clock: drive at negedge, check against the model, advance the model, wait the edge.
  task automatic cycle(input bit v, input logic [3:0] c, input logic [1:0] t, input bit rr,
                       input bit cl, input bit rs);
    bit   exp_ready, popped;
    exp_t e;
    @(negedge clk);
    req_valid = v;
    req_code  = c;
    req_tag   = t;
    rsp_ready = rr;
    clear     = cl;
    rst       = rs;
    #1;
    exp_ready = !m_rst_q && !cl && (m_q.size() != Depth);
    check("req_ready", req_ready, exp_ready);
    check("sat_req_ready", s_req_ready, exp_ready);
    if (m_q.size() == 0) begin
      check("rsp_valid", rsp_valid, 0);
      check("rsp_idx", rsp_idx, 0);
      check("rsp_err", rsp_err, 0);
      check("rsp_tag", rsp_tag, 0);
    end else begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_idx", rsp_idx, m_q[0].idx);
      check("rsp_err", rsp_err, m_q[0].err);
      check("rsp_tag", rsp_tag, m_q[0].tag);
    end
    check("err_cnt", err_cnt, m_err);
    check("sat_err_cnt", s_err_cnt, m_err_sat);

    m_acc  = v && exp_ready;
    popped = (m_q.size() != 0) && rr && !cl;
    if (rs) begin
      m_q.delete();
      m_err     = 0;
      m_err_sat = 0;
      m_rst_q   = 1'b1;
    end else begin
      m_rst_q = 1'b0;
      if (cl) begin
        m_q.delete();
        m_err     = 0;
        m_err_sat = 0;
      end else begin
        if (popped) void'(m_q.pop_front());
        if (m_acc) begin
          e = model_decode(c, t);
          m_q.push_back(e);
          if (e.err) begin
            if (m_err < 255) m_err++;
            if (m_err_sat < 3) m_err_sat++;
          end
        end
      end
    end
    @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 1ms", $time);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    bit          pv;
    logic [3:0]  pc;
    logic [1:0]  pt;

    // Reset and release; req_ready stays low for one cycle after release.
    cycle(0, 4'h0, 2'd0, 0, 0, 1);
    cycle(0, 4'h0, 2'd0, 0, 0, 1);
    cycle(0, 4'h0, 2'd0, 0, 0, 0);
    cycle(0, 4'h0, 2'd0, 0, 0, 0);

    // Single well-formed request: visible one cycle after accept.
    cycle(1, 4'b0100, 2'd2, 0, 0, 0);
    #1;
    check("t1_valid", rsp_valid, 1);
    check("t1_idx", rsp_idx, 2);
    check("t1_err", rsp_err, 0);
    check("t1_tag", rsp_tag, 2);
    cycle(0, 4'h0, 2'd0, 1, 0, 0);

    // Malformed codes.
    cycle(1, 4'b0000, 2'd1, 1, 0, 0);
    cycle(1, 4'b1010, 2'd3, 1, 0, 0);
    #1;
    check("t2_idx", rsp_idx, 1);
    check("t2_err", rsp_err, 1);
    check("t2_cnt", err_cnt, 2);
    cycle(0, 4'h0, 2'd0, 1, 0, 0);

    // Backpressure: five requests into a four-deep FIFO.
    n = 0;
    repeat (6) begin
      cycle(1, onehot(n), 2'(n), 0, 0, 0);
      if (m_acc) n++;
    end
    #1;
    check("bp_ready_low", req_ready, 0);
    check("bp_valid", rsp_valid, 1);
    repeat (10) begin
      cycle(n < 5, onehot(n), 2'(n), 1, 0, 0);
      if (m_acc) n++;
    end
    #1;
    check("bp_drained", rsp_valid, 0);
    check("bp_ready_high", req_ready, 1);

    // Steady push+pop at occupancy 1 across pointer wrap.
    cycle(1, onehot(0), 2'd0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) cycle(1, onehot(i), 2'(i), 1, 0, 0);
    #1;
    check("pp_valid", rsp_valid, 1);
    check("pp_tag", rsp_tag, 20 % 4);
    cycle(0, 4'h0, 2'd0, 1, 0, 0);

    // Saturation in the 2-bit counter, then clear.
    for (int i = 0; i < 5; i++) cycle(1, (i % 2 == 0) ? 4'b0000 : 4'b1111, 2'(i), 1, 0, 0);
    #1;
    check("sat_cnt", s_err_cnt, 3);
    cycle(1, 4'b0000, 2'd0, 0, 1, 0);
    #1;
    check("clr_cnt", err_cnt, 0);
    check("clr_sat_cnt", s_err_cnt, 0);
    check("clr_valid", rsp_valid, 0);

    // Reset with three entries buffered.
    for (int i = 0; i < 3; i++) cycle(1, onehot(i), 2'(i + 1), 0, 0, 0);
    cycle(0, 4'h0, 2'd0, 0, 0, 1);
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_tag", rsp_tag, 0);
    check("rst_ready", req_ready, 0);
    cycle(0, 4'h0, 2'd0, 1, 0, 0);
    repeat (3) cycle(0, 4'h0, 2'd0, 1, 0, 0);

    // Random traffic; a request stays stable until accepted.
    pv = 1'b0;
    pc = '0;
    pt = '0;
    m_acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!pv || m_acc) begin
        pv = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) < 2) pc = onehot($urandom_range(0, 3));
        else pc = 4'($urandom);
        pt = 2'($urandom);
      end
      cycle(pv, pc, pt, $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 89) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/onehot_decode_responder.md
Name: onehot_decode_responder

Overview:
- Responder-side decoder for the 2-to-4 one-hot code produced by the team's function-style encoder (my_func-class blocks): accepts one-hot codes over a valid/ready request channel and returns the binary index plus an error flag over a valid/ready response channel.
- Buffers results in a small in-order FIFO so the requester can issue back-to-back requests.
- Keeps a saturating count of malformed codes.

Parameters:
- CODE_W, 4: one-hot code width; must be a power of 2, ≥ 2. IDX_W = $clog2(CODE_W) is a derived localparam.
- TAG_W, 2: request tag width; the tag is returned unchanged with the response.
- DEPTH, 4: response FIFO entries; must be a power of 2, ≥ 2.
- CNT_W, 8: error counter width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of the FIFO and the error counter.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_code  in  CODE_W  code to decode.
- req_tag  in  TAG_W  requester tag.
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  requester consumes the response.
- rsp_idx  out  IDX_W  decoded index.
- rsp_err  out  1  code was not exactly one-hot.
- rsp_tag  out  TAG_W  echoed tag.
- err_cnt  out  CNT_W  saturating count of accepted malformed codes.

Behaviour:
- Reset (rst = 1 at an edge): FIFO empty, rd/wr pointers 0, count 0, err_cnt 0. During and after reset: rsp_valid = 0, rsp_idx = 0, rsp_err = 0, rsp_tag = 0, req_ready = 0.
- req_ready = !rst_q && !clear && (count != DEPTH), where rst_q is rst registered. req_ready is therefore low for the first cycle after reset release.
- Accept condition: req_valid && req_ready at an edge. The decoded entry {idx, err, tag} is written at that edge.
- Decode rules:
  - Exactly one bit set: idx = its position, err = 0.
  - Zero bits set: idx = 0, err = 1.
  - More than one bit set: idx = lowest set bit position, err = 1.
- Latency: a request accepted at edge N has rsp_valid = 1 after edge N, i.e. 1 cycle. There is no same-cycle combinational bypass.
- Response outputs are driven from the FIFO head and are stable while rsp_valid && !rsp_ready. Pop condition: rsp_valid && rsp_ready.
- rsp_idx, rsp_err and rsp_tag are held at 0 when the FIFO is empty, never X.
- Order is strictly FIFO; responses are never reordered or dropped.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged, permitted at any occupancy where the push is accepted.
  - When full, req_ready = 0 even if a pop occurs that cycle (no full-pass-through).
- Pointers are IDX-style $clog2(DEPTH)-bit and wrap naturally modulo DEPTH.
- err_cnt increments by 1 on each accepted request with err = 1 and saturates at 2^CNT_W−1.
- clear = 1 at an edge: FIFO emptied, err_cnt = 0, no push. A pop in that cycle is discarded. rsp_valid = 0 from the next cycle.
- rst has priority over clear. Reset asserted mid-stream discards all buffered responses.
- Internal occupancy states: EMPTY (count = 0), PARTIAL, FULL (count = DEPTH). Transitions follow the count update above; clear or rst returns to EMPTY.
- Requester protocol obligation (bench checks it, RTL does not): req_code and req_tag are held stable while req_valid && !req_ready.

Decomposition:
- Shared package onehot_pkg:
  - rsp_entry_t struct {idx, err, tag}.
  - Localparam function for IDX_W.
  - Default constants for CODE_W and TAG_W.
  - The encoder block also imports this package.
- One natural sub-module: onehot_rsp_fifo, a parameterised synchronous FIFO of rsp_entry_t with push, pop, clear, full, empty and count.
- The decode logic stays in the top level as a function.

Test Plan:
- Reset then single request code=4'b0100, tag=2 → rsp_valid one cycle after accept; idx=2, err=0, tag=2; err_cnt=0.
- Codes 4'b0000 and 4'b1010 → {idx=0, err=1} and {idx=1, err=1}; err_cnt=2.
- rsp_ready=0 with 5 back-to-back requests (DEPTH=4) → 4 accepted, req_ready=0 after the 4th. Raise rsp_ready → responses in order, FIFO drains, req_ready returns high.
- Continuous push+pop at occupancy 1 for 20 cycles, tags 0..3 cycling → occupancy stays 1; tags return in order; pointer wrap is seamless.
- CNT_W=2, 5 malformed codes → err_cnt saturates at 3. Then clear → err_cnt=0 and rsp_valid=0 next cycle.
- Assert rst with 3 entries buffered → rsp_valid=0 and all response outputs 0 after the edge; req_ready low for one cycle after release; no stale responses appear afterwards.
